// File: rtl/adc_request_scheduler.sv
// adc_request_scheduler
//   Shares one ADC between NUM_REQ requesters. Requesters are served one at a
//   time in round-robin order. For each conversion the scheduler latches the
//   owner's configuration, pulses the ADC start line, and then waits for the
//   synchronized finish edge or for a timeout. It captures the result and
//   releases the ADC once the finish flag has dropped again.
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   req_in                     per-requester level request
//   req_config_1_in/_2_in      packed 16-bit configs, requester i at [16i+15:16i]
//   grant_out                  one-hot current owner, 0 when idle
//   result_out                 last captured ADC result
//   result_valid_out           one-cycle one-hot result strobe for the owner
//   timeout_err_out            one-cycle pulse when a conversion times out
//   busy_out                   high whenever the scheduler is not idle
//   adc_start_conversion_out   start pulse to the ADC (two cycles)
//   adc_config_1_out/_2_out    config of the current/last owner
//   adc_result_in              ADC result, stable while the finish flag is high
//   adc_conversion_finished_in ADC finish flag (asynchronous)
module adc_request_scheduler #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_in,
   input  logic [16*NUM_REQ-1:0]   req_config_1_in,
   input  logic [16*NUM_REQ-1:0]   req_config_2_in,
   output logic [NUM_REQ-1:0]      grant_out,
   output logic [15:0]             result_out,
   output logic [NUM_REQ-1:0]      result_valid_out,
   output logic                    timeout_err_out,
   output logic                    busy_out,
   output logic                    adc_start_conversion_out,
   output logic [15:0]             adc_config_1_out,
   output logic [15:0]             adc_config_2_out,
   input  logic [15:0]             adc_result_in,
   input  logic                    adc_conversion_finished_in
);

   localparam int unsigned PTR_W = $clog2(NUM_REQ);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT,
      S_CAPTURE,
      S_RELEASE
   } state_t;

   state_t               state, state_nxt;
   logic                 fin_s1, fin_s2, fin_s3;
   logic                 fin_edge;
   logic [9:0]           wait_cnt;
   logic                 timeout_hit;
   logic                 start_cnt;
   logic [PTR_W-1:0]     rr_ptr;
   logic [2*NUM_REQ-1:0] req_dbl;
   logic [NUM_REQ-1:0]   req_rot;
   logic                 sel_vld;
   logic [PTR_W-1:0]     sel_off;
   logic [PTR_W-1:0]     sel_idx;

   assign fin_edge    = fin_s2 & ~fin_s3;
   assign timeout_hit = (wait_cnt == 10'(TIMEOUT_CYCLES));

   // Rotate requests so that bit 0 is the requester right after the last
   // grant. The lowest set bit of the rotated vector is then the winner.
   always_comb begin
      req_dbl = {req_in, req_in};
      req_rot = NUM_REQ'(req_dbl >> (rr_ptr + PTR_W'(1)));
      sel_vld = 1'b0;
      sel_off = '0;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         if (req_rot[j] && !sel_vld) begin
            sel_vld = 1'b1;
            sel_off = PTR_W'(j);
         end
      end
      sel_idx = rr_ptr + PTR_W'(1) + sel_off;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (sel_vld) state_nxt = S_START;
         S_START:   if (start_cnt) state_nxt = S_WAIT;
         S_WAIT: begin
            // The finish edge takes priority over a simultaneous timeout.
            if (fin_edge)         state_nxt = S_CAPTURE;
            else if (timeout_hit) state_nxt = S_RELEASE;
         end
         S_CAPTURE: state_nxt = S_RELEASE;
         S_RELEASE: if (!fin_s2) state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   assign busy_out                 = (state != S_IDLE);
   assign adc_start_conversion_out = (state == S_START);
   assign timeout_err_out          = (state == S_WAIT) && !fin_edge && timeout_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fin_s1           <= 1'b0;
         fin_s2           <= 1'b0;
         fin_s3           <= 1'b0;
         wait_cnt         <= '0;
         start_cnt        <= 1'b0;
         rr_ptr           <= '1;
         grant_out        <= '0;
         result_out       <= '0;
         result_valid_out <= '0;
         adc_config_1_out <= '0;
         adc_config_2_out <= '0;
      end else begin
         fin_s1           <= adc_conversion_finished_in;
         fin_s2           <= fin_s1;
         fin_s3           <= fin_s2;
         result_valid_out <= '0;
         case (state)
            S_IDLE: begin
               if (sel_vld) begin
                  grant_out        <= NUM_REQ'(1) << sel_idx;
                  rr_ptr           <= sel_idx;
                  adc_config_1_out <= req_config_1_in[16*sel_idx +: 16];
                  adc_config_2_out <= req_config_2_in[16*sel_idx +: 16];
                  start_cnt        <= 1'b0;
               end
            end
            S_START: begin
               start_cnt <= 1'b1;
               if (start_cnt) wait_cnt <= '0;
            end
            S_WAIT: begin
               if (wait_cnt != '1) wait_cnt <= wait_cnt + 10'd1;
            end
            S_CAPTURE: begin
               result_out       <= adc_result_in;
               // A requester that dropped its request gets no strobe.
               result_valid_out <= grant_out & req_in;
            end
            default: ;
         endcase
         if (state_nxt == S_RELEASE) grant_out <= '0;
      end
   end

endmodule

// File: tb/tb_adc_request_scheduler.sv
// tb_adc_request_scheduler
//   Directed and randomized transactions against adc_request_scheduler with
//   TIMEOUT_CYCLES = 100. Expected grants come from a round-robin pointer
//   model; expected results, strobes and timeout positions come from the
//   stimulus the bench itself drives.
module tb_adc_request_scheduler;

   localparam int unsigned TMO = 100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req_in = '0;
   logic [63:0] req_config_1_in = '0;
   logic [63:0] req_config_2_in = '0;
   logic [3:0]  grant_out;
   logic [15:0] result_out;
   logic [3:0]  result_valid_out;
   logic        timeout_err_out;
   logic        busy_out;
   logic        adc_start_conversion_out;
   logic [15:0] adc_config_1_out;
   logic [15:0] adc_config_2_out;
   logic [15:0] adc_result_in = '0;
   logic        adc_conversion_finished_in = 1'b0;

   int unsigned errors = 0;
   int unsigned checks = 0;
   int unsigned last   = 3;

   adc_request_scheduler #(.NUM_REQ(4), .TIMEOUT_CYCLES(TMO)) dut (
      .clk                        (clk),
      .rst                        (rst),
      .req_in                     (req_in),
      .req_config_1_in            (req_config_1_in),
      .req_config_2_in            (req_config_2_in),
      .grant_out                  (grant_out),
      .result_out                 (result_out),
      .result_valid_out           (result_valid_out),
      .timeout_err_out            (timeout_err_out),
      .busy_out                   (busy_out),
      .adc_start_conversion_out   (adc_start_conversion_out),
      .adc_config_1_out           (adc_config_1_out),
      .adc_config_2_out           (adc_config_2_out),
      .adc_result_in              (adc_result_in),
      .adc_conversion_finished_in (adc_conversion_finished_in)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Round-robin rule: first requesting index after the last grant.
   function automatic int unsigned rr_pick(input int unsigned lst, input logic [3:0] pat);
      for (int unsigned k = 1; k <= 4; k++)
         if (pat[(lst + k) % 4]) return (lst + k) % 4;
      return 0;
   endfunction

   task automatic do_txn(input logic [3:0] pat, input logic [63:0] c1, input logic [63:0] c2,
                         input bit tmo, input int unsigned fin_dly, input logic [15:0] res,
                         input bit drop, input int unsigned hold, input bit keep);
      int unsigned idx, n, vcnt, bad;
      logic [3:0]  exp_g, vseen;
      logic [15:0] e_c1, e_c2;
      bit          tseen;
      idx   = rr_pick(last, pat);
      exp_g = 4'b0001 << idx;
      e_c1  = c1[16*idx +: 16];
      e_c2  = c2[16*idx +: 16];
      req_config_1_in = c1;
      req_config_2_in = c2;
      req_in = pat;
      n = 0;
      while (grant_out == 4'b0000 && n < 20) begin @(negedge clk); n++; end
      chk("grant", grant_out, exp_g);
      chk("cfg1_at_grant", adc_config_1_out, e_c1);
      chk("cfg2_at_grant", adc_config_2_out, e_c2);
      chk("start_with_grant", adc_start_conversion_out, 1'b1);
      chk("busy_with_grant", busy_out, 1'b1);
      last = idx;
      // Configs must stay latched even though the inputs now change.
      req_config_1_in = {$urandom, $urandom};
      req_config_2_in = {$urandom, $urandom};
      n = 0;
      while (adc_start_conversion_out && n < 10) begin n++; @(negedge clk); end
      chk("start_len", n, 2);
      if (drop) req_in[idx] = 1'b0;
      if (tmo) begin
         n = 0;
         while (!timeout_err_out && n < TMO + 10) begin @(negedge clk); n++; end
         chk("timeout_cycle", n, TMO);
         chk("valid_at_timeout", result_valid_out, 4'b0000);
         @(negedge clk);
         chk("timeout_one_cycle", timeout_err_out, 1'b0);
         chk("grant_after_timeout", grant_out, 4'b0000);
         chk("valid_after_timeout", result_valid_out, 4'b0000);
      end else begin
         tseen = 1'b0;
         for (int unsigned i = 0; i < fin_dly; i++) begin
            @(negedge clk);
            if (timeout_err_out) tseen = 1'b1;
         end
         adc_result_in = res;
         adc_conversion_finished_in = 1'b1;
         vcnt  = 0;
         vseen = '0;
         for (int unsigned i = 0; i < 8; i++) begin
            @(negedge clk);
            if (timeout_err_out) tseen = 1'b1;
            if (result_valid_out != 4'b0000) vcnt++;
            vseen |= result_valid_out;
         end
         chk("no_timeout", tseen, 1'b0);
         chk("result", result_out, res);
         chk("valid_value", vseen, drop ? 4'b0000 : exp_g);
         chk("valid_count", vcnt, drop ? 0 : 1);
         chk("grant_in_release", grant_out, 4'b0000);
         chk("busy_in_release", busy_out, 1'b1);
         bad = 0;
         for (int unsigned h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!busy_out || grant_out != 4'b0000) bad++;
         end
         chk("release_hold", bad, 0);
      end
      if (!keep || drop) req_in = '0;
      adc_conversion_finished_in = 1'b0;
      n = 0;
      while (busy_out && n < 10) begin @(negedge clk); n++; end
      chk("idle_after_release", busy_out, 1'b0);
      chk("grant_idle", grant_out, 4'b0000);
      chk("cfg1_stable", adc_config_1_out, e_c1);
      chk("cfg2_stable", adc_config_2_out, e_c2);
   endtask

   initial begin
      int unsigned n, vcnt, bcnt;
      logic [3:0]  pat;
      logic [63:0] c1;
      bit          keep, drop, tmo;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_grant", grant_out, 4'b0000);
      chk("rst_result", result_out, 16'h0000);
      chk("rst_valid", result_valid_out, 4'b0000);
      chk("rst_timeout", timeout_err_out, 1'b0);
      chk("rst_busy", busy_out, 1'b0);
      chk("rst_start", adc_start_conversion_out, 1'b0);
      chk("rst_cfg", {adc_config_1_out, adc_config_2_out}, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // Single conversion with a known config and result
      c1 = {$urandom, $urandom};
      c1[15:0] = 16'h0C07;
      do_txn(4'b0001, c1, {$urandom, $urandom}, 1'b0, 38, 16'h0ABC, 1'b0, 3, 1'b0);

      // All requesters held: round-robin order 1,2,3,0 after the first grant
      for (int unsigned k = 0; k < 5; k++)
         do_txn(4'b1111, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 15,
                16'($urandom), 1'b0, 0, k != 4);

      // Timeout with no finish
      do_txn(4'b0100, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 0, 16'h0, 1'b0, 0, 1'b0);

      // Requester drops during the conversion
      do_txn(4'b0010, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 20, 16'h1234, 1'b1, 0, 1'b0);

      // Finish flag held high long after release
      do_txn(4'b1000, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 10, 16'h5A5A, 1'b0, 50, 1'b0);

      // Finish edge on the same cycle the timeout would fire
      do_txn(4'b0001, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, TMO - 2, 16'hBEEF, 1'b0, 0, 1'b0);

      // Reset in the middle of WAIT, then a stale finish from the aborted conversion
      req_in = 4'b0110;
      n = 0;
      while (grant_out == 4'b0000 && n < 20) begin @(negedge clk); n++; end
      repeat (6) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_grant", grant_out, 4'b0000);
      chk("midrst_busy", busy_out, 1'b0);
      chk("midrst_start", adc_start_conversion_out, 1'b0);
      chk("midrst_result", result_out, 16'h0000);
      chk("midrst_cfg", {adc_config_1_out, adc_config_2_out}, 32'h0);
      repeat (2) @(negedge clk);
      req_in = '0;
      rst = 1'b0;
      last = 3;
      @(negedge clk);
      adc_result_in = 16'hDEAD;
      adc_conversion_finished_in = 1'b1;
      vcnt = 0;
      bcnt = 0;
      for (int unsigned i = 0; i < 10; i++) begin
         @(negedge clk);
         if (result_valid_out != 4'b0000 || timeout_err_out) vcnt++;
         if (busy_out) bcnt++;
      end
      chk("stale_no_valid", vcnt, 0);
      chk("stale_idle", bcnt, 0);
      chk("stale_result", result_out, 16'h0000);
      adc_conversion_finished_in = 1'b0;
      repeat (4) @(negedge clk);
      do_txn(4'b0001, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 25, 16'h0F0F, 1'b0, 0, 1'b0);

      // Randomized transactions
      pat = 4'b0001;
      keep = 1'b0;
      for (int unsigned t = 0; t < 25; t++) begin
         if (!keep) pat = 4'($urandom_range(1, 15));
         tmo  = ($urandom_range(0, 5) == 0);
         drop = ($urandom_range(0, 5) == 0);
         keep = !drop && ($urandom_range(0, 2) == 0);
         do_txn(pat, {$urandom, $urandom}, {$urandom, $urandom}, tmo,
                $urandom_range(0, TMO - 8), 16'($urandom), drop,
                $urandom_range(0, 10), keep);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/adc_request_scheduler.md
ADC_REQUEST_SCHEDULER -- requirements
Module: adc_request_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one ADC; fixed at 4 for this revision.
REQ-002 Parameter TIMEOUT_CYCLES, default 1023, max clk cycles waiting for conversion finish; range 16..1023.
REQ-003 clk  input  1  scheduler clock; single clock domain, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_in  input  4  per-requester conversion request, level, bit i = requester i.
REQ-006 req_config_1_in  input  64  requester i config_1 at bits [16i+15:16i].
REQ-007 req_config_2_in  input  64  requester i config_2 at bits [16i+15:16i].
REQ-008 grant_out  output  4  one-hot owner of ADC; 0 when idle.
REQ-009 result_out  output  16  last captured ADC result.
REQ-010 result_valid_out  output  4  one-cycle one-hot pulse, result_out valid for that requester.
REQ-011 timeout_err_out  output  1  one-cycle pulse, active conversion aborted by timeout.
REQ-012 busy_out  output  1  high in any state except IDLE.
REQ-013 adc_start_conversion_out  output  1  start pulse to ADC top.
REQ-014 adc_config_1_out / adc_config_2_out  output  16 each  config driven to ADC top.
REQ-015 adc_result_in  input  16  ADC result, stable while finish flag high.
REQ-016 adc_conversion_finished_in  input  1  ADC finish flag, asynchronous to clk.

Function
REQ-017 States: IDLE, START, WAIT, CAPTURE, RELEASE; encoding free.
REQ-018 adc_conversion_finished_in passes a 2-flop synchronizer; "finish edge" = synchronized 0->1 transition, detected with a third flop.
REQ-019 IDLE: if req_in != 0, grant next requester round-robin starting at (last_grant+1) mod 4; go START next cycle.
REQ-020 Round-robin pointer after reset = requester 3, so requester 0 wins first; pointer updates only on grant.
REQ-021 At grant, selected requester's config_1/config_2 latch into adc_config_*_out and stay constant until next grant.
REQ-022 START: adc_start_conversion_out high exactly 2 consecutive cycles, then WAIT; start low in all other states.
REQ-023 WAIT: 10-bit counter clears on entry, increments per cycle, saturates; finish edge -> CAPTURE.
REQ-024 WAIT: counter == TIMEOUT_CYCLES without finish edge -> timeout_err_out pulse 1 cycle, no result_valid, go RELEASE.
REQ-025 CAPTURE: register adc_result_in into result_out; pulse result_valid_out[owner] next cycle only if req_in[owner] still high; go RELEASE.
REQ-026 Requester dropping req_in mid-conversion: conversion completes, result_out still updates, no valid pulse.
REQ-027 RELEASE: grant_out -> 0; wait until synchronized finish flag low, then IDLE (guarantees no stale edge).
REQ-028 Finish edge and timeout on same cycle: finish edge wins.
REQ-029 Minimum one IDLE cycle between grants; a requester holding req_in high is re-served only after others by round-robin.
REQ-030 Finish edge outside WAIT ignored.
REQ-031 result_valid_out and timeout_err_out never both high; result_valid_out at most one bit set.

Reset
REQ-032 On rst: state IDLE, grant_out 0, result_out 0, result_valid_out 0, timeout_err_out 0, busy_out 0, adc_start_conversion_out 0, adc_config_*_out 0, synchronizer flops 0, counter 0, pointer 3.
REQ-033 rst asserted mid-conversion aborts immediately with all outputs to reset values; after release, a finish edge from the aborted conversion is ignored (state IDLE).

Verification
REQ-034 req_in=0001, cfg1[0]=0x0C07; finish rises 40 cycles after start, result 0x0ABC -> start high 2 cycles, adc_config_1_out=0x0C07, result_out=0x0ABC, result_valid_out=0001 one cycle.
REQ-035 req_in=1111 held, each conversion 20 cycles -> grants in order 0001,0010,0100,1000,0001; no two grants overlap.
REQ-036 req_in=0100, finish never rises, TIMEOUT_CYCLES=100 -> timeout_err_out pulse at WAIT cycle 100, no valid, grant 0 after finish low.
REQ-037 req_in=0010 dropped to 0 during WAIT, result 0x1234 -> result_out=0x1234, result_valid_out stays 0.
REQ-038 rst pulsed during WAIT, then finish rises -> all outputs reset values, no valid pulse, next req_in=0001 granted normally.
REQ-039 finish already high when entering RELEASE held 50 cycles -> state remains RELEASE, busy_out high until finish low, then IDLE.
